// File: rtl/alu_seq.sv
// Multi-cycle unsigned ALU: single-cycle add/subtract, shift-add multiply and
// restoring divide, one result bit per clock for the iterative operations.
module alu_seq #(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [1:0]   control,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] op,
    output logic [W-1:0] op_hi,
    output logic         c_out,
    output logic         div_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    logic [1:0]    state_reg;
    logic [CW-1:0] cnt_reg;
    logic [1:0]    ctl_reg;
    logic [W-1:0]  arg_reg;   // multiplicand or divisor
    logic [W:0]    hi_reg;    // MUL: carry + high half; DIV: partial remainder
    logic [W-1:0]  lo_reg;    // MUL: multiplier/product low; DIV: dividend/quotient
    logic [W:0]    hi_next;
    logic [W-1:0]  lo_next;

    logic [W:0]    add_sum;
    logic [W:0]    mul_sum;
    logic [W:0]    rem_sh;
    logic [W+1:0]  div_trial;

    assign add_sum   = {1'b0, A} + {1'b0, B};
    assign mul_sum   = hi_reg + (lo_reg[0] ? {1'b0, arg_reg} : '0);
    assign rem_sh    = {hi_reg[W-1:0], lo_reg[W-1]};
    assign div_trial = {1'b0, rem_sh} - {2'b00, arg_reg};

    always_comb begin
        hi_next = hi_reg;
        lo_next = lo_reg;
        if (ctl_reg == OP_DIV) begin
            // Top bit of the trial difference is the borrow: restore on borrow.
            if (div_trial[W+1]) begin
                hi_next = rem_sh;
                lo_next = {lo_reg[W-2:0], 1'b0};
            end else begin
                hi_next = div_trial[W:0];
                lo_next = {lo_reg[W-2:0], 1'b1};
            end
        end else begin
            hi_next = {1'b0, mul_sum[W:1]};
            lo_next = {mul_sum[0], lo_reg[W-1:1]};
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == FIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ctl_reg   <= '0;
            arg_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            op        <= '0;
            op_hi     <= '0;
            c_out     <= 1'b0;
            div_err   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        ctl_reg <= control;
                        arg_reg <= B;
                        div_err <= 1'b0;
                        case (control)
                            OP_ADD: begin
                                op        <= add_sum[W-1:0];
                                op_hi     <= '0;
                                c_out     <= add_sum[W];
                                state_reg <= FIN;
                            end
                            OP_SUB: begin
                                op        <= A - B;
                                op_hi     <= '0;
                                c_out     <= (A < B);
                                state_reg <= FIN;
                            end
                            OP_MUL: begin
                                hi_reg    <= '0;
                                lo_reg    <= A;
                                cnt_reg   <= CW'(W);
                                state_reg <= CALC;
                            end
                            default: begin
                                if (B == '0) begin
                                    op        <= '1;
                                    op_hi     <= A;
                                    c_out     <= 1'b0;
                                    div_err   <= 1'b1;
                                    state_reg <= FIN;
                                end else begin
                                    hi_reg    <= '0;
                                    lo_reg    <= A;
                                    cnt_reg   <= CW'(W);
                                    state_reg <= CALC;
                                end
                            end
                        endcase
                    end
                end
                CALC: begin
                    hi_reg <= hi_next;
                    lo_reg <= lo_next;
                    if (cnt_reg != '0)
                        cnt_reg <= cnt_reg - 1'b1;
                    // Last iteration: publish the freshly computed step directly.
                    if (cnt_reg == CW'(1)) begin
                        op        <= lo_next;
                        op_hi     <= hi_next[W-1:0];
                        c_out     <= (ctl_reg == OP_MUL) ? (|hi_next[W-1:0]) : 1'b0;
                        state_reg <= FIN;
                    end
                end
                FIN:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
